exec_sequencer: RTL and testbench
=================================

# exec_sequencer

Multi-cycle control unit for the 16-bit accumulator processor. Each instruction runs in three cycles: fetch, decode, execute. The block latches the 24-bit ROM word (8-bit opcode plus 16-bit operand) into an instruction register and drives the datapath controls: PC, accumulator, register file, immediate mux and ALU opcode. It replaces the purely combinational decoder, adding run/pause, halt, an illegal-opcode trap and a registered zero flag.

## Interface
- `WIDTH`, 16, datapath/operand width
- `OP_W`, 8, opcode width
- `clk_in`  in  1  system clock
- `rst_in`  in  1  synchronous reset, active-low
- `run_in`  in  1  level; 1 = execute, 0 = pause at next instruction boundary
- `instr_in`  in  24  ROM word at the current PC
- `alu_zero_in`  in  1  ALU zero output, valid in EXEC
- `pc_inc`  out  1  PC += 1 this edge
- `pc_load`  out  1  PC <= `operand` this edge
- `acu_en`  out  1  accumulator capture
- `rf_en`  out  1  register-file access
- `rf_wr`  out  1  1 = write accumulator to register `operand[3:0]`, 0 = read
- `ldi_sel`  out  1  mux selects immediate operand
- `alu_op`  out  8  opcode to ALU
- `operand`  out  16  IR operand field
- `zflag`  out  1  registered zero flag
- `halted`  out  1  in HALT state
- `illegal`  out  1  sticky; set when halt was caused by an undefined opcode

## Operation
- States:
  - IDLE: `run_in`=1 -> FETCH.
  - FETCH: IR <= `instr_in` -> DECODE.
  - DECODE: drive `alu_op`, `ldi_sel`, `rf_en` (read) -> EXEC.
  - EXEC: perform the action, then -> FETCH if `run_in`=1, else IDLE.
  - HALT: absorbing.
- Opcodes (IR[23:16]):
  - 0x00 NOP: EXEC `pc_inc`.
  - 0x01 LDI: `ldi_sel`=1, `acu_en`, `pc_inc`, zflag <= `alu_zero_in`.
  - 0x02 ADD / 0x03 SUB: `ldi_sel`=0, `rf_en`=1 read in DECODE and EXEC; EXEC `acu_en`, `pc_inc`, zflag <= `alu_zero_in`.
  - 0x04 ST: EXEC `rf_en`=1, `rf_wr`=1, `pc_inc`. Accumulator and zflag unchanged.
  - 0x05 JMP: EXEC `pc_load`, no `pc_inc`.
  - 0x06 JZ / 0x07 JNZ: conditional; see Configuration.
  - 0xFF HALT: EXEC -> HALT, no PC change.
  - Any other opcode: EXEC -> HALT, `illegal`=1, no datapath enables.
- `pc_inc` and `pc_load` are never both 1.
- `acu_en` and `rf_wr` are never both 1.
- Every enable is 0 outside EXEC, except `rf_en` read during DECODE of ADD/SUB.
- `operand` and `alu_op` are held from DECODE through EXEC.
- Deasserting `run_in` never aborts an instruction in flight: the current instruction completes, then the block parks in IDLE.
- HALT is left only by reset. `run_in` is ignored in HALT.

## Timing
- Reset (`rst_in`=0 at an edge):
  - State = IDLE; IR = 0; `zflag`, `halted`, `illegal` = 0; all enables 0; `alu_op` = 0; `operand` = 0.
  - Reset mid-instruction discards it: no enable is asserted in the reset cycle.
- Throughput: 3 cycles per instruction with `run_in` held at 1. From IDLE, add 1 cycle.
- `halted` rises on the edge after the EXEC of HALT or of an illegal opcode.
- zflag updates on the EXEC edge. A conditional jump immediately following an ADD/SUB/LDI sees the new value.
- `run_in` is sampled only in IDLE and at the end of EXEC.

## Configuration
- Macro: `EXEC_SEQ_COND_JUMP_EN`.
- Defined:
  - JZ: `pc_load` if zflag=1, else `pc_inc`.
  - JNZ: `pc_load` if zflag=0, else `pc_inc`.
- Undefined: 0x06 and 0x07 decode as illegal and the block traps to HALT.

## Structure
- Shared package `proc_pkg`:
  - opcode localparams (OP_NOP, OP_LDI, OP_ADD, OP_SUB, OP_ST, OP_JMP, OP_JZ, OP_JNZ, OP_HALT);
  - state enum typedef (`seq_state_t`);
  - the instruction-word field split (opcode 23:16, operand 15:0).
- One natural sub-module: `exec_decode`, a combinational opcode-to-control-vector lookup including the illegal flag. The sequencer gates its outputs by state.

## Test plan
- Reset then `run_in`=1, program LDI 5; ST r2; HALT -> `acu_en` and `pc_inc` at cycle 3, `rf_wr`=1 with operand 2 at cycle 6, `halted`=1 after cycle 9, `illegal`=0.
- LDI 0 then JZ 0x000A with the macro defined -> zflag=1 and `pc_load`=1 with operand 0x000A. Without the macro -> `illegal`=1 and the block halts.
- ADD producing a nonzero result (`alu_zero_in`=0), then JNZ 3 -> `pc_load`. Repeat with `alu_zero_in`=1 -> `pc_inc` only.
- Opcode 0x42 -> no enables in EXEC, `halted`=1, `illegal`=1; toggling `run_in` afterward has no effect.
- `run_in` dropped during DECODE -> current instruction still completes its EXEC, then IDLE. Reasserting `run_in` resumes with FETCH one cycle later.
- `rst_in`=0 during the EXEC cycle of ST -> no `rf_wr` pulse; all outputs return to their reset values.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared definitions for the accumulator processor: opcodes, instruction
// field layout, sequencer states and the decoded control vector.
package proc_pkg;

   localparam int OPC_W   = 8;
   localparam int OPD_W   = 16;
   localparam int INSTR_W = OPC_W + OPD_W;
   localparam int OPC_LSB = OPD_W;

   localparam logic [7:0] OP_NOP  = 8'h00;
   localparam logic [7:0] OP_LDI  = 8'h01;
   localparam logic [7:0] OP_ADD  = 8'h02;
   localparam logic [7:0] OP_SUB  = 8'h03;
   localparam logic [7:0] OP_ST   = 8'h04;
   localparam logic [7:0] OP_JMP  = 8'h05;
   localparam logic [7:0] OP_JZ   = 8'h06;
   localparam logic [7:0] OP_JNZ  = 8'h07;
   localparam logic [7:0] OP_HALT = 8'hFF;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_HALT   = 3'd4
   } seq_state_t;

   // cond_inv selects JNZ polarity; rf_rd_dec marks a register read already in DECODE.
   typedef struct packed {
      logic pc_inc;
      logic pc_load;
      logic cond_jump;
      logic cond_inv;
      logic acu_en;
      logic rf_rd_dec;
      logic rf_en;
      logic rf_wr;
      logic ldi_sel;
      logic zf_upd;
      logic halt;
      logic illegal;
   } ctrl_t;

endpackage

// File: rtl/exec_decode.sv
// Combinational opcode-to-control lookup. JZ/JNZ decode as conditional jumps
// only when EXEC_SEQ_COND_JUMP_EN is defined; otherwise they trap as illegal.
module exec_decode
   import proc_pkg::*;
#(
   parameter int OP_W = OPC_W
) (
   input  logic [OP_W-1:0] opcode,
   output ctrl_t           ctrl
);

   always_comb begin
      ctrl = '0;
      case (opcode)
         OP_NOP: ctrl.pc_inc = 1'b1;
         OP_LDI: begin
            ctrl.ldi_sel = 1'b1;
            ctrl.acu_en  = 1'b1;
            ctrl.pc_inc  = 1'b1;
            ctrl.zf_upd  = 1'b1;
         end
         OP_ADD, OP_SUB: begin
            ctrl.rf_rd_dec = 1'b1;
            ctrl.rf_en     = 1'b1;
            ctrl.acu_en    = 1'b1;
            ctrl.pc_inc    = 1'b1;
            ctrl.zf_upd    = 1'b1;
         end
         OP_ST: begin
            ctrl.rf_en  = 1'b1;
            ctrl.rf_wr  = 1'b1;
            ctrl.pc_inc = 1'b1;
         end
         OP_JMP: ctrl.pc_load = 1'b1;
`ifdef EXEC_SEQ_COND_JUMP_EN
         OP_JZ:  ctrl.cond_jump = 1'b1;
         OP_JNZ: begin
            ctrl.cond_jump = 1'b1;
            ctrl.cond_inv  = 1'b1;
         end
`else
         OP_JZ, OP_JNZ: begin
            ctrl.halt    = 1'b1;
            ctrl.illegal = 1'b1;
         end
`endif
         OP_HALT: ctrl.halt = 1'b1;
         default: begin
            ctrl.halt    = 1'b1;
            ctrl.illegal = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/exec_sequencer.sv
// Three-cycle fetch/decode/execute sequencer for the accumulator processor.
// Conditional jumps are enabled by defining EXEC_SEQ_COND_JUMP_EN.
module exec_sequencer
   import proc_pkg::*;
#(
   parameter int WIDTH = OPD_W,
   parameter int OP_W  = OPC_W
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic                  run_in,
   input  logic [OP_W+WIDTH-1:0] instr_in,
   input  logic                  alu_zero_in,
   output logic                  pc_inc,
   output logic                  pc_load,
   output logic                  acu_en,
   output logic                  rf_en,
   output logic                  rf_wr,
   output logic                  ldi_sel,
   output logic [OP_W-1:0]       alu_op,
   output logic [WIDTH-1:0]      operand,
   output logic                  zflag,
   output logic                  halted,
   output logic                  illegal
);

   seq_state_t              state_reg, state_next;
   logic [OP_W+WIDTH-1:0]   ir_reg;
   logic                    zflag_reg;
   logic                    illegal_reg;
   ctrl_t                   ctrl;
   logic                    in_exec, in_decode, jump_taken;

   exec_decode #(.OP_W(OP_W)) u_decode (
      .opcode (ir_reg[WIDTH +: OP_W]),
      .ctrl   (ctrl)
   );

   // Qualifying with rst_in keeps a reset cycle free of any datapath enable.
   assign in_exec    = rst_in && (state_reg == S_EXEC);
   assign in_decode  = rst_in && (state_reg == S_DECODE);
   assign jump_taken = zflag_reg ^ ctrl.cond_inv;

   assign pc_inc  = in_exec && (ctrl.pc_inc  || (ctrl.cond_jump && !jump_taken));
   assign pc_load = in_exec && (ctrl.pc_load || (ctrl.cond_jump &&  jump_taken));
   assign acu_en  = in_exec && ctrl.acu_en;
   assign rf_wr   = in_exec && ctrl.rf_wr;
   assign rf_en   = (in_exec && ctrl.rf_en) || (in_decode && ctrl.rf_rd_dec);
   assign ldi_sel = (in_exec || in_decode) && ctrl.ldi_sel;

   assign alu_op  = ir_reg[WIDTH +: OP_W];
   assign operand = ir_reg[WIDTH-1:0];
   assign zflag   = zflag_reg;
   assign halted  = (state_reg == S_HALT);
   assign illegal = illegal_reg;

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE:   state_next = run_in ? S_FETCH : S_IDLE;
         S_FETCH:  state_next = S_DECODE;
         S_DECODE: state_next = S_EXEC;
         S_EXEC: begin
            if (ctrl.halt)
               state_next = S_HALT;
            else
               state_next = run_in ? S_FETCH : S_IDLE;
         end
         S_HALT:   state_next = S_HALT;
         default:  state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         state_reg   <= S_IDLE;
         ir_reg      <= '0;
         zflag_reg   <= 1'b0;
         illegal_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         if (state_reg == S_FETCH)
            ir_reg <= instr_in;
         if (in_exec && ctrl.zf_upd)
            zflag_reg <= alu_zero_in;
         if (in_exec && ctrl.illegal)
            illegal_reg <= 1'b1;
      end
   end

endmodule

// File: tb/tb_exec_sequencer.sv
// Scoreboard bench for exec_sequencer: a small ROM/PC model feeds instructions,
// expected EXEC/DECODE actions and halt events are queued and checked by a monitor.
module tb_exec_sequencer;

   logic        clk_in = 1'b0;
   logic        rst_in = 1'b0;
   logic        run_in = 1'b0;
   logic [23:0] instr_in;
   logic        alu_zero_in = 1'b0;
   logic        pc_inc, pc_load, acu_en, rf_en, rf_wr, ldi_sel;
   logic [7:0]  alu_op;
   logic [15:0] operand;
   logic        zflag, halted, illegal;

   exec_sequencer #(.WIDTH(16), .OP_W(8)) dut (
      .clk_in      (clk_in),
      .rst_in      (rst_in),
      .run_in      (run_in),
      .instr_in    (instr_in),
      .alu_zero_in (alu_zero_in),
      .pc_inc      (pc_inc),
      .pc_load     (pc_load),
      .acu_en      (acu_en),
      .rf_en       (rf_en),
      .rf_wr       (rf_wr),
      .ldi_sel     (ldi_sel),
      .alu_op      (alu_op),
      .operand     (operand),
      .zflag       (zflag),
      .halted      (halted),
      .illegal     (illegal)
   );

   typedef struct packed {
      logic        ev;     // 0 = enable activity, 1 = halted rising
      logic [15:0] rel;
      logic        pi, pl, ae, re, rw, ls;
      logic [7:0]  op;
      logic [15:0] opd;
      logic        z;
      logic        ill;
   } exp_t;

   exp_t        exp_q[$];
   string       name_q[$];
   int          vectors = 0;
   int          miscompares = 0;
   int          cyc = 0;
   int          run_cyc = 0;
   logic [23:0] rom [16];
   logic [15:0] pc = 16'h0000;
   logic        prev_halted = 1'b0;

   always #5 clk_in = ~clk_in;
   always @(posedge clk_in) cyc <= cyc + 1;

   // Program counter model driven by the sequencer's PC controls
   always @(posedge clk_in) begin
      if (!rst_in)      pc <= 16'h0000;
      else if (pc_load) pc <= operand;
      else if (pc_inc)  pc <= pc + 16'h0001;
   end
   assign instr_in = rom[pc[3:0]];

   function automatic exp_t mk_ev(input logic ev, input int rel,
                                  input logic pi, input logic pl, input logic ae,
                                  input logic re, input logic rw, input logic ls,
                                  input logic [7:0] op, input logic [15:0] opd,
                                  input logic z, input logic ill);
      exp_t e;
      e.ev = ev; e.rel = 16'(rel);
      e.pi = pi; e.pl = pl; e.ae = ae; e.re = re; e.rw = rw; e.ls = ls;
      e.op = op; e.opd = opd; e.z = z; e.ill = ill;
      return e;
   endfunction

   function automatic string fmt(input exp_t e);
      return $sformatf("ev=%0d rel=%0d pi/pl/ae/re/rw/ls=%b%b%b%b%b%b op=%h opd=%h z=%b ill=%b",
                       e.ev, e.rel, e.pi, e.pl, e.ae, e.re, e.rw, e.ls, e.op, e.opd, e.z, e.ill);
   endfunction

   task automatic push(input string n, input exp_t e);
      exp_q.push_back(e);
      name_q.push_back(n);
   endtask

   // Monitor: every cycle with an enable or a rising halted is one transaction
   always @(negedge clk_in) begin
      exp_t  got, e;
      string n;
      logic  commit, hrise;
      commit = (pc_inc | pc_load | acu_en | rf_en | rf_wr) === 1'b1;
      hrise  = (halted === 1'b1) && (prev_halted !== 1'b1);
      prev_halted = halted;
      if ((pc_inc & pc_load) === 1'b1 || (acu_en & rf_wr) === 1'b1) begin
         vectors++;
         miscompares++;
         $display("FAIL exclusive_enables got pc_inc/pc_load/acu_en/rf_wr=%b%b%b%b want no pair set",
                  pc_inc, pc_load, acu_en, rf_wr);
      end
      if (commit || hrise) begin
         got.ev = hrise; got.rel = 16'(cyc - run_cyc);
         got.pi = pc_inc; got.pl = pc_load; got.ae = acu_en;
         got.re = rf_en;  got.rw = rf_wr;   got.ls = ldi_sel;
         got.op = alu_op; got.opd = operand; got.z = zflag; got.ill = illegal;
         vectors++;
         if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_event got %s want none", fmt(got));
         end else begin
            e = exp_q.pop_front();
            n = name_q.pop_front();
            if (got !== e) begin
               miscompares++;
               $display("FAIL %s got %s want %s", n, fmt(got), fmt(e));
            end else begin
               $display("ok   %s %s", n, fmt(got));
            end
         end
      end
   end

   task automatic check(input string n, input logic [63:0] got, input logic [63:0] want);
      vectors++;
      if (got !== want) begin
         miscompares++;
         $display("FAIL %s got=%h want=%h", n, got, want);
      end else begin
         $display("ok   %s value=%h", n, got);
      end
   endtask

   task automatic reset_dut(input string n);
      run_in = 1'b0;
      rst_in = 1'b0;
      repeat (2) @(posedge clk_in);
      @(negedge clk_in);
      check(n, {pc_inc, pc_load, acu_en, rf_en, rf_wr, ldi_sel, alu_op, operand,
                zflag, halted, illegal, pc}, 64'h0);
      rst_in = 1'b1;
   endtask

   task automatic start_run();
      @(negedge clk_in);
      run_cyc = cyc;
      run_in  = 1'b1;
   endtask

   task automatic wait_halted(input string n, input int budget);
      for (int i = 0; i < budget && halted !== 1'b1; i++) @(negedge clk_in);
      if (halted !== 1'b1) begin
         vectors++;
         miscompares++;
         $display("FAIL %s_timeout got halted=%b want 1 within %0d cycles", n, halted, budget);
      end
      repeat (2) @(negedge clk_in);
   endtask

   task automatic check_drained(input string n);
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL %s_drained got %0d pending, next %s want 0", n, exp_q.size(), name_q[0]);
         exp_q.delete();
         name_q.delete();
      end else begin
         $display("ok   %s_drained", n);
      end
   endtask

   task automatic fill_rom();
      for (int i = 0; i < 16; i++) rom[i] = 24'hFF0000;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog got no finish want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // T1: LDI 5; ST r2; HALT
      fill_rom();
      rom[0] = 24'h010005; rom[1] = 24'h040002; rom[2] = 24'hFF0000;
      alu_zero_in = 1'b0;
      reset_dut("t1_reset");
      push("t1_ldi",  mk_ev(0, 3, 1,0,1,0,0,1, 8'h01, 16'h0005, 0, 0));
      push("t1_st",   mk_ev(0, 6, 1,0,0,1,1,0, 8'h04, 16'h0002, 0, 0));
      push("t1_halt", mk_ev(1, 10, 0,0,0,0,0,0, 8'hFF, 16'h0000, 0, 0));
      start_run();
      wait_halted("t1", 30);
      check_drained("t1");

      // T2: LDI 0; JZ 0x000A
      fill_rom();
      rom[0] = 24'h010000; rom[1] = 24'h06000A; rom[10] = 24'hFF0000;
      alu_zero_in = 1'b1;
      reset_dut("t2_reset");
      push("t2_ldi", mk_ev(0, 3, 1,0,1,0,0,1, 8'h01, 16'h0000, 0, 0));
`ifdef EXEC_SEQ_COND_JUMP_EN
      push("t2_jz_taken", mk_ev(0, 6, 0,1,0,0,0,0, 8'h06, 16'h000A, 1, 0));
      push("t2_halt",     mk_ev(1, 10, 0,0,0,0,0,0, 8'hFF, 16'h0000, 1, 0));
`else
      push("t2_jz_trap",  mk_ev(1, 7, 0,0,0,0,0,0, 8'h06, 16'h000A, 1, 1));
`endif
      start_run();
      wait_halted("t2", 30);
      check_drained("t2");

      // T3: ADD r1 (nonzero); JNZ 3
      fill_rom();
      rom[0] = 24'h020001; rom[1] = 24'h070003; rom[2] = 24'hFF0002; rom[3] = 24'hFF0003;
      alu_zero_in = 1'b0;
      reset_dut("t3_reset");
      push("t3_add_dec",  mk_ev(0, 2, 0,0,0,1,0,0, 8'h02, 16'h0001, 0, 0));
      push("t3_add_exec", mk_ev(0, 3, 1,0,1,1,0,0, 8'h02, 16'h0001, 0, 0));
`ifdef EXEC_SEQ_COND_JUMP_EN
      push("t3_jnz_taken", mk_ev(0, 6, 0,1,0,0,0,0, 8'h07, 16'h0003, 0, 0));
      push("t3_halt",      mk_ev(1, 10, 0,0,0,0,0,0, 8'hFF, 16'h0003, 0, 0));
`else
      push("t3_jnz_trap",  mk_ev(1, 7, 0,0,0,0,0,0, 8'h07, 16'h0003, 0, 1));
`endif
      start_run();
      wait_halted("t3", 30);
      check_drained("t3");

      // T4: SUB r1 (zero); JNZ 3 falls through
      alu_zero_in = 1'b1;
      rom[0] = 24'h030001;
      reset_dut("t4_reset");
      push("t4_sub_dec",  mk_ev(0, 2, 0,0,0,1,0,0, 8'h03, 16'h0001, 0, 0));
      push("t4_sub_exec", mk_ev(0, 3, 1,0,1,1,0,0, 8'h03, 16'h0001, 0, 0));
`ifdef EXEC_SEQ_COND_JUMP_EN
      push("t4_jnz_fall", mk_ev(0, 6, 1,0,0,0,0,0, 8'h07, 16'h0003, 1, 0));
      push("t4_halt",     mk_ev(1, 10, 0,0,0,0,0,0, 8'hFF, 16'h0002, 1, 0));
`else
      push("t4_jnz_trap", mk_ev(1, 7, 0,0,0,0,0,0, 8'h07, 16'h0003, 1, 1));
`endif
      start_run();
      wait_halted("t4", 30);
      check_drained("t4");

      // T5: undefined opcode 0x42 traps; run_in toggling afterwards is ignored
      fill_rom();
      rom[0] = 24'h420000;
      alu_zero_in = 1'b0;
      reset_dut("t5_reset");
      push("t5_illegal", mk_ev(1, 4, 0,0,0,0,0,0, 8'h42, 16'h0000, 0, 1));
      start_run();
      wait_halted("t5", 20);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk_in);
         run_in = ~run_in;
      end
      @(negedge clk_in);
      check("t5_stay_halted", {halted, illegal, pc}, {46'h0, 1'b1, 1'b1, 16'h0000});
      check_drained("t5");

      // T6: run_in dropped in DECODE of NOP, then resumed
      fill_rom();
      rom[0] = 24'h000000; rom[1] = 24'hFF0000;
      reset_dut("t6_reset");
      push("t6_nop", mk_ev(0, 3, 1,0,0,0,0,0, 8'h00, 16'h0000, 0, 0));
      start_run();
      while (cyc < run_cyc + 2) @(negedge clk_in);
      run_in = 1'b0;
      repeat (5) @(negedge clk_in);
      check("t6_parked", {halted, pc}, {47'h0, 1'b0, 16'h0001});
      push("t6_halt", mk_ev(1, 4, 0,0,0,0,0,0, 8'hFF, 16'h0000, 0, 0));
      run_cyc = cyc;
      run_in  = 1'b1;
      wait_halted("t6", 20);
      check_drained("t6");

      // T7: reset asserted during EXEC of ST
      fill_rom();
      rom[0] = 24'h010000; rom[1] = 24'h040002; rom[2] = 24'hFF0000;
      alu_zero_in = 1'b1;
      reset_dut("t7_reset");
      push("t7_ldi", mk_ev(0, 3, 1,0,1,0,0,1, 8'h01, 16'h0000, 0, 0));
      start_run();
      while (cyc < run_cyc + 5) @(negedge clk_in);
      check("t7_zflag_set", {63'h0, zflag}, 64'h1);
      @(posedge clk_in);
      #1;
      rst_in = 1'b0;
      run_in = 1'b0;
      @(negedge clk_in);
      check("t7_no_st_enables", {pc_inc, pc_load, acu_en, rf_en, rf_wr}, 64'h0);
      @(posedge clk_in);
      @(negedge clk_in);
      check("t7_reset_values", {pc_inc, pc_load, acu_en, rf_en, rf_wr, ldi_sel, alu_op, operand,
                                zflag, halted, illegal, pc}, 64'h0);
      rst_in = 1'b1;
      repeat (3) @(negedge clk_in);
      check_drained("t7");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
